// File: rtl/uart_pkg.sv
// uart_pkg: shared UART line-control layout, TX states and frame timing.
// Exports lcr_t, tx_state_e, stop/bit length constants and parity helpers.
package uart_pkg;

   typedef struct packed {
      logic       dlab;
      logic       set_break;
      logic       sticky_parity;
      logic       eps;
      logic       pen;
      logic       stb;
      logic [1:0] wls;
   } lcr_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Lengths in baud pulses at the nominal 16x oversample.
   localparam int BIT_LEN        = 16;
   localparam int STOP_LEN_1     = 16;
   localparam int STOP_LEN_15    = 24;
   localparam int STOP_LEN_2     = 32;
   localparam int DATA_BITS_BASE = 5;

   function automatic logic [7:0] data_mask(input logic [1:0] wls);
      return 8'hFF >> (2'd3 - wls);
   endfunction

   // Parity over the data bits actually sent.
   function automatic logic tx_parity(input logic [7:0] d,
                                      input lcr_t       l);
      logic [7:0] m;
      m = d & data_mask(l.wls);
      if (l.sticky_parity)
         return ~l.eps;
      return l.eps ? ^m : ~^m;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts baud ticks up to a loadable length.
// Ports: tick_i baud pulse, load_i/len_i restart with a new length,
// done_o one-cycle pulse on the len-th tick; restarts itself after done.
module uart_bit_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_i,
   input  logic         load_i,
   input  logic [W-1:0] len_i,
   output logic         done_o
);

   localparam logic [W-1:0] ONE = 1;

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] len_q, len_d;
   logic         last;

   assign last   = (cnt_q == len_q - ONE);
   assign done_o = tick_i & last;

   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      if (load_i) begin
         cnt_d = '0;
         len_d = len_i;
      end else if (tick_i) begin
         cnt_d = last ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 16550-style serial transmitter fed from the TX FIFO.
// Ports: clk/rst (async high), baud_i 16x pulse, lcr_i line control,
// tx_fifo_empty_i/tx_fifo_dout_i FIFO head, tx_pop_o pop strobe,
// tx_o serial line, busy_o frame active, temt_o transmitter empty.
// Macro UART_TX_BREAK_EN: lcr_i.set_break forces tx_o low live.
module uart_tx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_i,
   input  logic [7:0] lcr_i,
   input  logic       tx_fifo_empty_i,
   input  logic [7:0] tx_fifo_dout_i,
   output logic       tx_pop_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       temt_o
);

   localparam logic [5:0] LEN_BIT =
      6'(OVERSAMPLE);
   localparam logic [5:0] LEN_S1 =
      6'(STOP_LEN_1 * OVERSAMPLE / BIT_LEN);
   localparam logic [5:0] LEN_S15 =
      6'(STOP_LEN_15 * OVERSAMPLE / BIT_LEN);
   localparam logic [5:0] LEN_S2 =
      6'(STOP_LEN_2 * OVERSAMPLE / BIT_LEN);

   tx_state_e  state_q, state_d;
   lcr_t       lcr_q, lcr_d, lcr_in;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   logic       par_q, par_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       pop;
   logic       line;
   logic       brk;
   logic       tmr_load;
   logic [5:0] tmr_len;
   logic       tmr_done;
   logic [5:0] stop_len;
   logic [2:0] last_bit;
   logic       unused_lcr;

   assign lcr_in     = lcr_t'(lcr_i);
   assign unused_lcr = ^{lcr_q.dlab, lcr_q.set_break};

`ifdef UART_TX_BREAK_EN
   assign brk = lcr_in.set_break;
`else
   assign brk = 1'b0;
`endif

   assign last_bit = 3'(DATA_BITS_BASE - 1) + {1'b0, lcr_q.wls};

   always_comb begin
      stop_len = LEN_S1;
      if (lcr_q.stb)
         stop_len = (lcr_q.wls == 2'b00) ? LEN_S15 : LEN_S2;
   end

   uart_bit_timer #(
      .W(6)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .tick_i(baud_i),
      .load_i(tmr_load),
      .len_i (tmr_len),
      .done_o(tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      lcr_d    = lcr_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      par_d    = par_q;
      pop      = 1'b0;
      tmr_load = 1'b0;
      tmr_len  = LEN_BIT;
      unique case (state_q)
         IDLE: begin
            if (!tx_fifo_empty_i)
               pop = 1'b1;
         end
         START: begin
            if (tmr_done) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tmr_done) begin
               if (bit_q == last_bit) begin
                  if (lcr_q.pen) begin
                     state_d = PARITY;
                  end else begin
                     state_d  = STOP;
                     tmr_load = 1'b1;
                     tmr_len  = stop_len;
                  end
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (tmr_done) begin
               state_d  = STOP;
               tmr_load = 1'b1;
               tmr_len  = stop_len;
            end
         end
         STOP: begin
            if (tmr_done) begin
               if (!tx_fifo_empty_i)
                  pop = 1'b1;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Capture a new frame: data, format and parity are frozen here.
      if (pop) begin
         state_d  = START;
         shift_d  = tx_fifo_dout_i;
         lcr_d    = lcr_in;
         par_d    = tx_parity(tx_fifo_dout_i, lcr_in);
         bit_d    = '0;
         tmr_load = 1'b1;
         tmr_len  = LEN_BIT;
      end
   end

   // Line level follows the state being entered, so tx_o moves
   // one clock after the terminating baud pulse.
   always_comb begin
      line = 1'b1;
      unique case (state_d)
         IDLE:    line = 1'b1;
         START:   line = 1'b0;
         DATA:    line = shift_d[0];
         PARITY:  line = par_d;
         STOP:    line = 1'b1;
         default: line = 1'b1;
      endcase
      tx_d   = line & ~brk;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lcr_q   <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lcr_q   <= lcr_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_pop_o = pop;
   assign tx_o     = tx_q;
   assign busy_o   = busy_q;
   assign temt_o   = tx_fifo_empty_i & ~busy_q;

endmodule
